// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem requests, 1-entry skid buffer, EX redirect/flush.
// Optional misaligned-redirect fault detection is compiled in with `define FETCH_MISALIGN_CHK_EN.
`timescale 1ns/1ps
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        fetch_misalign,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request is accepted in the cycle imem_req && imem_gnt; its single response
  // arrives later as a one-cycle imem_rvalid. An instruction leaves the output register in the
  // cycle if_valid && !stall_i; the register only loads when it is empty or being consumed.

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] out_pc, out_pc_n;
  logic        kill, kill_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic        if_valid_n;
  logic [31:0] if_pc_n, if_inst_n;
  logic        can_load;
  logic [31:0] tgt_aligned;
  logic        unused_tgt_bits;

  assign can_load        = !if_valid || !stall_i;
  assign tgt_aligned     = {redirect_target[31:2], 2'b00};
  assign unused_tgt_bits = ^redirect_target[1:0];

  // Request is a pure function of state; gated by reset so it stays low while rst_n is held.
  assign imem_req  = rst_n && (state == S_REQ);
  assign imem_addr = pc;
  assign dbg_state = state;

`ifdef FETCH_MISALIGN_CHK_EN
  assign fetch_misalign = (state == S_FAULT);
`else
  assign fetch_misalign = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    out_pc_n    = out_pc;
    kill_n      = kill;
    hold_pc_n   = hold_pc;
    hold_inst_n = hold_inst;
    if_valid_n  = if_valid;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;

    if (if_valid && !stall_i) begin
      if_valid_n = 1'b0;
    end

    if (redirect_valid) begin
      // Flush wins over stall; a request already granted is marked to be discarded on return.
      if_valid_n = 1'b0;
      pc_n       = tgt_aligned;
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            kill_n  = 1'b1;
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            kill_n  = 1'b1;
          end
        end
        S_HOLD: begin
          state_n = S_REQ;
        end
`ifdef FETCH_MISALIGN_CHK_EN
        S_FAULT: begin
          if (kill && !imem_rvalid) begin
            state_n = S_WAIT;
          end else begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end
        end
`endif
        default: begin
          state_n = S_REQ;
        end
      endcase
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_target[1]) begin
        state_n = S_FAULT;
      end
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            out_pc_n = pc;
            pc_n     = pc + 32'd4;
            state_n  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_n = S_REQ;
            if (kill) begin
              kill_n = 1'b0;
            end else if (can_load) begin
              if_valid_n = 1'b1;
              if_pc_n    = out_pc;
              if_inst_n  = imem_rdata;
            end else begin
              hold_pc_n   = out_pc;
              hold_inst_n = imem_rdata;
              state_n     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            if_valid_n = 1'b1;
            if_pc_n    = hold_pc;
            if_inst_n  = hold_inst;
            state_n    = S_REQ;
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        S_FAULT: begin
          // A wrong-path response may still drain while parked here.
          if (imem_rvalid) begin
            kill_n = 1'b0;
          end
        end
`endif
        default: begin
          state_n = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      out_pc    <= RESET_PC;
      kill      <= 1'b0;
      hold_pc   <= 32'd0;
      hold_inst <= NOP_INST;
      if_valid  <= 1'b0;
      if_pc     <= 32'd0;
      if_inst   <= NOP_INST;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_pc    <= out_pc_n;
      kill      <= kill_n;
      hold_pc   <= hold_pc_n;
      hold_inst <= hold_inst_n;
      if_valid  <= if_valid_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: imem responder, delivered-PC scoreboard, cycle-exact checks.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_misalign;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // responder controls
  logic        gnt_en = 1'b0;
  int          rdelay = 1;
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .fetch_misalign  (fetch_misalign),
    .dbg_state       (dbg_state)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_idle"}, {31'd0, if_valid}, 32'd0);
  endtask

  // ---------------- imem responder ----------------
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    pend        = 1'b0;
    pend_addr   = 32'd0;
    cnt         = 0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(pend_addr);
            pend        = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (imem_req && gnt_en && !pend) begin
          imem_gnt  = 1'b1;
          pend      = 1'b1;
          pend_addr = imem_addr;
          cnt       = rdelay - 1;
        end
      end
    end
  end

  // ---------------- scoreboard: every consumed instruction must be expected ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && if_valid && !stall_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'd0, if_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pc_out", if_pc, e);
          check("inst_out", if_inst, inst_of(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n           = 1'b0;
    stall_i         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    tick();
    tick();
    check("rst_req",      {31'd0, imem_req}, 32'd0);
    check("rst_addr",     imem_addr, 32'h0000_0000);
    check("rst_valid",    {31'd0, if_valid}, 32'd0);
    check("rst_pc",       if_pc, 32'd0);
    check("rst_inst",     if_inst, 32'h0000_0013);
    check("rst_misalign", {31'd0, fetch_misalign}, 32'd0);

    // sequential fetch, one instruction every two cycles
    rst_n  = 1'b1;
    gnt_en = 1'b1;
    rdelay = 1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    tick();
    check("seq_req0",  {31'd0, imem_req}, 32'd1);
    check("seq_addr0", imem_addr, 32'h0);
    tick();
    check("seq_wait_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("seq_valid0", {31'd0, if_valid}, 32'd1);
    check("seq_pc0",    if_pc, 32'h0);
    check("seq_inst0",  if_inst, 32'hC0DE_0013);
    check("seq_addr1",  imem_addr, 32'h4);
    tick();
    tick();
    check("seq_pc1",   if_pc, 32'h4);
    check("seq_inst1", if_inst, 32'hC0DE_0017);
    check("seq_addr2", imem_addr, 32'h8);
    gnt_en = 1'b0;
    tick();
    tick();
    check("seq_pc2",   if_pc, 32'h8);
    check("seq_inst2", if_inst, 32'hC0DE_001B);
    check("seq_addr3", imem_addr, 32'hC);
    drain("seq");

    // stall while a response is outstanding: lands in the hold buffer
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    gnt_en = 1'b1;
    tick();
    check("stl_addr", imem_addr, 32'hC);
    tick();
    tick();
    check("stl_pc_c", if_pc, 32'hC);
    stall_i = 1'b1;
    gnt_en  = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_req",   {31'd0, imem_req}, 32'd0);
      check("stl_pc",    if_pc, 32'hC);
      check("stl_valid", {31'd0, if_valid}, 32'd1);
    end
    stall_i = 1'b0;
    tick();
    check("stl_rel_pc",   if_pc, 32'h10);
    check("stl_rel_inst", if_inst, 32'hC0DE_0003);
    check("stl_rel_addr", imem_addr, 32'h14);
    drain("stl");

    // redirect in S_WAIT, killed response arrives two cycles later
    gnt_en = 1'b1;
    rdelay = 3;
    tick();
    check("rdw_addr", imem_addr, 32'h14);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("rdw_flush", {31'd0, if_valid}, 32'd0);
    check("rdw_req",   {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    check("rdw_req_tgt", {31'd0, imem_req}, 32'd1);
    check("rdw_addr_tgt", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    gnt_en = 1'b0;
    drain("rdw");

    // redirect coincident with gnt
    rdelay = 2;
    gnt_en = 1'b1;
    tick();
    check("rdg_addr", imem_addr, 32'h104);
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    gnt_en          = 1'b0;
    tick();
    redirect_valid = 1'b0;
    check("rdg_flush", {31'd0, if_valid}, 32'd0);
    check("rdg_req",   {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    check("rdg_addr_tgt", imem_addr, 32'h200);
    check("rdg_req_tgt", {31'd0, imem_req}, 32'd1);
    exp_q.push_back(32'h200);
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    drain("rdg");

    // redirect coincident with rvalid
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    check("rdr_addr", imem_addr, 32'h204);
    tick();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check("rdr_flush",    {31'd0, if_valid}, 32'd0);
    check("rdr_req_tgt",  {31'd0, imem_req}, 32'd1);
    check("rdr_addr_tgt", imem_addr, 32'h300);
    exp_q.push_back(32'h300);
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    drain("rdr");

    // PC wrap at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrp_addr_top", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    gnt_en = 1'b1;
    rdelay = 1;
    tick();
    tick();
    tick();
    check("wrp_addr_zero", imem_addr, 32'h0);
    gnt_en = 1'b0;
    drain("wrp");

    // redirect with bit 1 set
    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    check("mis_req",  {31'd0, imem_req}, 32'd0);
    gnt_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mis_hold_req",  {31'd0, imem_req}, 32'd0);
      check("mis_hold_flag", {31'd0, fetch_misalign}, 32'd1);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("mis_clr",      {31'd0, fetch_misalign}, 32'd0);
    check("mis_res_req",  {31'd0, imem_req}, 32'd1);
    check("mis_res_addr", imem_addr, 32'h200);
    exp_q.push_back(32'h200);
    gnt_en = 1'b0;
    drain("mis");
`else
    check("mis_flag", {31'd0, fetch_misalign}, 32'd0);
    check("mis_req",  {31'd0, imem_req}, 32'd1);
    check("mis_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    drain("mis");
`endif

    // reset mid-transaction abandons the fetch and restarts at RESET_PC
    gnt_en = 1'b1;
    rdelay = 3;
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_req",   {31'd0, imem_req}, 32'd0);
    check("mrst_valid", {31'd0, if_valid}, 32'd0);
    check("mrst_inst",  if_inst, 32'h0000_0013);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_req1", {31'd0, imem_req}, 32'd1);
    gnt_en = 1'b0;
    drain("mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

- Instruction-fetch front end of the CPU pipeline.
- Holds the fetch PC and issues single-outstanding requests to instruction memory.
- Delivers fetched instructions to the IF/ID register.
- Consumes the jump/branch target produced in EX (`redirect_target`) to redirect the PC and flush wrong-path instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports (clock is `clk`; reset is `rst_n`, asynchronous, active-low):
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  IF/ID hold from the hazard unit; output register must not change while high.
- redirect_valid  in  1  one-cycle pulse from EX: branch taken or jump.
- redirect_target  in  32  new PC. Bit 0 is already cleared by EX; bit 1 may be set.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word-aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid. Arrives at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_pc/if_inst hold a valid instruction.
- if_pc  out  32  PC of the delivered instruction.
- if_inst  out  32  delivered instruction.
- fetch_misalign  out  1  misaligned-redirect fault. Exists only with FETCH_MISALIGN_CHK_EN; tied 0 otherwise.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `out_pc`: address of the outstanding request.
  - `kill`: discard the next response.
  - `hold_pc` / `hold_inst`: 1-entry skid buffer.
  - Output register: `if_valid`, `if_pc`, `if_inst`.
- Output register loads when `!if_valid || !stall_i`. The instruction is consumed when `if_valid && !stall_i`.
- States:
  - S_REQ: `imem_req=1`, `imem_addr=pc`. On gnt: `out_pc<=pc`, `pc<=pc+4` (mod 2^32), go S_WAIT.
  - S_WAIT: `imem_req=0`. On rvalid:
    - If `kill`: drop the data, clear `kill`, go S_REQ.
    - Else if the output register can load: load it with {`out_pc`, `rdata`}, go S_REQ.
    - Else: store into the hold buffer, go S_HOLD.
  - S_HOLD: `imem_req=0`. When `stall_i` falls: output register <= hold buffer, go S_REQ.
  - S_FAULT (macro only): `imem_req=0`, `fetch_misalign=1`.
- Redirect has priority over all other events in the same cycle:
  - `if_valid<=0`; hold buffer discarded.
  - `pc<=target`, word-aligned per Configuration.
  - In S_REQ with gnt in the same cycle: the granted request is wrong-path. Set `kill`, go S_WAIT.
  - In S_WAIT with no rvalid that cycle: set `kill`, stay in S_WAIT.
  - In S_WAIT with rvalid that cycle: drop the data, go S_REQ; `kill` stays 0.
  - In S_HOLD: go S_REQ.
  - Redirect overrides `stall_i` for the flush only.
- At most one outstanding request. At most two buffered instructions (output register + hold buffer), so no request is issued in S_HOLD.
- Reset values:
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `if_valid=0`, `if_pc=0`, `if_inst=32'h0000_0013` (NOP).
  - `fetch_misalign=0`, `kill=0`, `pc=RESET_PC`, state S_REQ.
- Reset asserted mid-transaction abandons everything immediately. A late rvalid after reset release, while in S_REQ, is ignored.

## Timing
- `imem_req` is combinational from state. It is first high in the first cycle after `rst_n` deasserts.
- Best-case throughput: one instruction per 2 cycles (gnt at N, rvalid at N+1, next req at N+2).
- Latency: rvalid at cycle T gives `if_valid` high from T+1.
- Redirect at cycle R:
  - `if_valid` is 0 at R+1.
  - The first request to the target is issued at R+1 if no wrong-path request is outstanding. Otherwise it is issued the cycle after the killed rvalid.
- `imem_addr` is stable while `imem_req` is high and gnt is low.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with `target[1]=1` enters S_FAULT and raises `fetch_misalign`. The flush and kill rules above still apply.
  - S_FAULT exits only on a redirect with `target[1]=0`, which loads `pc` and goes to S_REQ.
- FETCH_MISALIGN_CHK_EN undefined:
  - `pc<={target[31:2],2'b00}` silently.
  - `fetch_misalign` is tied 0 and S_FAULT does not exist.

## Test plan
- Reset, RESET_PC=0, gnt always 1, rvalid 1 cycle after gnt → imem_addr sequence 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 every 2 cycles; if_inst matches rdata.
- stall_i held for 5 cycles while a response is outstanding → response lands in S_HOLD, no imem_req during stall, if_pc unchanged. After release, the held instruction appears next cycle with no loss or duplication.
- Redirect to 0x100 while in S_WAIT, rvalid 2 cycles later → that response is discarded, if_valid 0, next imem_addr=0x100, if_pc=0x100 delivered.
- Redirect coincident with gnt, and separately coincident with rvalid → no wrong-path instruction ever reaches if_valid=1. Next fetch is at the target.
- pc=0xFFFF_FFFC fetched → next imem_addr wraps to 0x0000_0000.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102 → fetch_misalign=1, imem_req=0 indefinitely. Redirect to 0x200 → fetch_misalign=0 and fetch resumes at 0x200. Without the macro, redirect to 0x102 fetches 0x100.
